// File: rtl/timer_sched_pkg.sv
// Shared types and register map for the interval-timer sequencer.
// TIMER_SCHED_SNAP_EN adds the counter snapshot states.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_START,
        ST_RUN,
        ST_CLR,
        ST_WR_STOP,
        ST_CLR_FINAL
`ifdef TIMER_SCHED_SNAP_EN
        ,
        ST_SNAP_WR,
        ST_SNAP_A4,
        ST_SNAP_A5,
        ST_SNAP_HI
`endif
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_STOP_WORD = 16'(1) << CTRL_STOP;

    function automatic logic [15:0] ctrl_start_word(input logic cont);
        logic [15:0] w;
        w             = '0;
        w[CTRL_START] = 1'b1;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/timer_sched_ctrl_if.sv
// Avalon-MM connection between the sequencer and the timer's s1 port.
interface timer_sched_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/timer_sched_ctrl.sv
// Sequencer for a 16-bit-register interval timer: programs, starts, services and stops it.
// Optional counter snapshot enabled by TIMER_SCHED_SNAP_EN.
//
// state        | meaning
// -------------+-----------------------------------------------
// IDLE         | waiting for cmd_start
// WR_PL        | period_l write on the bus
// WR_PH        | period_h write on the bus
// WR_START     | control write (start, ITO, cont)
// RUN          | timer running, waiting for irq or stop
// CLR          | status write clearing the timeout, tick issued
// WR_STOP      | control write stopping the timer
// CLR_FINAL    | status write dropping any pending irq
// SNAP_WR      | snap_l write latching the timer counter
// SNAP_A4      | address 4 presented for read
// SNAP_A5      | low half captured, address 5 presented
// SNAP_HI      | high half captured, back to RUN
module timer_sched_ctrl
    import timer_sched_pkg::*;
#(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cmd_start,
    input  logic              cmd_stop,
`ifdef TIMER_SCHED_SNAP_EN
    input  logic              cmd_snap,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
`endif
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              cfg_err,
    timer_sched_ctrl_if.master tmr
);

    state_t      state;
    logic [15:0] per_hi_q;
    logic        cont_q;
    logic        stop_pend;
`ifdef TIMER_SCHED_SNAP_EN
    logic [15:0] snap_lo_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            cfg_err        <= 1'b0;
            tmr.address    <= ADDR_STATUS;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tmr.writedata  <= '0;
            per_hi_q       <= '0;
            cont_q         <= 1'b0;
            stop_pend      <= 1'b0;
`ifdef TIMER_SCHED_SNAP_EN
            snap_lo_q      <= '0;
            snap_value     <= '0;
            snap_valid     <= 1'b0;
`endif
        end else begin
            tick           <= 1'b0;
            cfg_err        <= 1'b0;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
`ifdef TIMER_SCHED_SNAP_EN
            snap_valid     <= 1'b0;
`endif
            // A stop seen anywhere in the sequence is remembered until it can be acted on
            if (state != ST_IDLE && cmd_stop)
                stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        if (cfg_period == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            per_hi_q       <= cfg_period[31:16];
                            cont_q         <= cfg_continuous;
                            tick_count     <= '0;
                            stop_pend      <= 1'b0;
                            tmr.chipselect <= 1'b1;
                            tmr.write_n    <= 1'b0;
                            tmr.address    <= ADDR_PERIODL;
                            tmr.writedata  <= cfg_period[15:0];
                            busy           <= 1'b1;
                            state          <= ST_WR_PL;
                        end
                    end
                end
                ST_WR_PL: begin
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_PERIODH;
                    tmr.writedata  <= per_hi_q;
                    state          <= ST_WR_PH;
                end
                ST_WR_PH: begin
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_CONTROL;
                    tmr.writedata  <= ctrl_start_word(cont_q);
                    state          <= ST_WR_START;
                end
                ST_WR_START: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (tmr.irq) begin
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_STATUS;
                        tmr.writedata  <= '0;
                        tick           <= 1'b1;
                        tick_count     <= tick_count + TICK_W'(1);
                        state          <= ST_CLR;
                    end else if (stop_pend || cmd_stop) begin
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_CONTROL;
                        tmr.writedata  <= CTRL_STOP_WORD;
                        state          <= ST_WR_STOP;
`ifdef TIMER_SCHED_SNAP_EN
                    end else if (cmd_snap) begin
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_SNAPL;
                        tmr.writedata  <= '0;
                        state          <= ST_SNAP_WR;
`endif
                    end
                end
                ST_CLR: begin
                    if (stop_pend || cmd_stop) begin
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_CONTROL;
                        tmr.writedata  <= CTRL_STOP_WORD;
                        state          <= ST_WR_STOP;
                    end else if (!cont_q) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_WR_STOP: begin
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_STATUS;
                    tmr.writedata  <= '0;
                    state          <= ST_CLR_FINAL;
                end
                ST_CLR_FINAL: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
`ifdef TIMER_SCHED_SNAP_EN
                // readdata trails the address by one cycle, hence the staggered capture
                ST_SNAP_WR: begin
                    tmr.chipselect <= 1'b1;
                    tmr.address    <= ADDR_SNAPL;
                    state          <= ST_SNAP_A4;
                end
                ST_SNAP_A4: begin
                    tmr.chipselect <= 1'b1;
                    tmr.address    <= ADDR_SNAPH;
                    state          <= ST_SNAP_A5;
                end
                ST_SNAP_A5: begin
                    snap_lo_q <= tmr.readdata;
                    state     <= ST_SNAP_HI;
                end
                ST_SNAP_HI: begin
                    snap_value <= {tmr.readdata, snap_lo_q};
                    snap_valid <= 1'b1;
                    state      <= ST_RUN;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Scoreboard bench for timer_sched_ctrl with a behavioural interval timer on the bus.
// Snapshot checks are built when TIMER_SCHED_SNAP_EN is defined.
module tb_timer_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic        cfg_err;
`ifdef TIMER_SCHED_SNAP_EN
    logic        cmd_snap = 1'b0;
    logic [31:0] snap_value;
    logic        snap_valid;
`endif

    timer_sched_ctrl_if tmr ();

    timer_sched_ctrl #(.TICK_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
`ifdef TIMER_SCHED_SNAP_EN
        .cmd_snap       (cmd_snap),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid),
`endif
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .cfg_err        (cfg_err),
        .tmr            (tmr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural interval timer: timeout after period+1 running clocks
    logic [31:0] t_period, t_cnt, t_snap;
    logic        t_run, t_cont, t_ito, t_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= '0; t_cnt <= '0; t_snap <= '0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
            tmr.readdata <= '0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (tmr.chipselect && !tmr.write_n) begin
                case (tmr.address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= tmr.writedata[0];
                        t_cont <= tmr.writedata[1];
                        if (tmr.writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                        if (tmr.writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: t_period[15:0]  <= tmr.writedata;
                    3'd3: t_period[31:16] <= tmr.writedata;
                    3'd4, 3'd5: t_snap <= t_cnt;
                    default: ;
                endcase
            end
            case (tmr.address)
                3'd2: tmr.readdata <= t_period[15:0];
                3'd3: tmr.readdata <= t_period[31:16];
                3'd4: tmr.readdata <= t_snap[15:0];
                3'd5: tmr.readdata <= t_snap[31:16];
                default: tmr.readdata <= {15'd0, t_to};
            endcase
        end
    end
    assign tmr.irq = t_to & t_ito;

    typedef struct { logic [2:0] a; logic [15:0] d; int c; } wr_t;
    typedef struct { int cnt; int c; } tk_t;
    wr_t exp_wr[$];
    tk_t exp_tk[$];
    int  exp_err[$];
    int  exp_snap[$];
    wr_t mw;
    tk_t mt;
    int  mc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d, input int c);
        wr_t w;
        w.a = a; w.d = d; w.c = c;
        exp_wr.push_back(w);
    endtask

    task automatic push_tk(input int cnt, input int c);
        tk_t t;
        t.cnt = cnt; t.c = c;
        exp_tk.push_back(t);
        push_wr(3'd0, 16'h0000, c);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called on a negedge; s is the edge that samples cmd_start
    task automatic start(input logic [31:0] p, input logic c, output int s);
        s = cyc + 1;
        if (p == 0) begin
            exp_err.push_back(s);
        end else begin
            push_wr(3'd2, p[15:0], s);
            push_wr(3'd3, p[31:16], s + 1);
            push_wr(3'd1, c ? 16'h0007 : 16'h0005, s + 2);
        end
        cfg_period = p; cfg_continuous = c; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (reset_n) begin
            if (tmr.chipselect && !tmr.write_n) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL bus_write unexpected addr=%0d data=%h cyc=%0d", tmr.address, tmr.writedata, cyc);
                end else begin
                    mw = exp_wr.pop_front();
                    if (tmr.address !== mw.a || tmr.writedata !== mw.d || cyc != mw.c) begin
                        errors++;
                        $display("FAIL bus_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                                 tmr.address, tmr.writedata, cyc, mw.a, mw.d, mw.c);
                    end
                end
            end
            if (tick) begin
                checks++;
                if (exp_tk.size() == 0) begin
                    errors++;
                    $display("FAIL tick unexpected count=%0d cyc=%0d", tick_count, cyc);
                end else begin
                    mt = exp_tk.pop_front();
                    if (tick_count != 16'(mt.cnt) || cyc != mt.c) begin
                        errors++;
                        $display("FAIL tick got count=%0d cyc=%0d expected count=%0d cyc=%0d",
                                 tick_count, cyc, mt.cnt, mt.c);
                    end
                end
            end
            if (cfg_err) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_err unexpected cyc=%0d", cyc);
                end else begin
                    mc = exp_err.pop_front();
                    if (cyc != mc) begin
                        errors++;
                        $display("FAIL cfg_err got cyc=%0d expected cyc=%0d", cyc, mc);
                    end
                end
            end
`ifdef TIMER_SCHED_SNAP_EN
            if (snap_valid) begin
                checks++;
                if (exp_snap.size() == 0) begin
                    errors++;
                    $display("FAIL snap_valid unexpected cyc=%0d", cyc);
                end else begin
                    mc = exp_snap.pop_front();
                    if (cyc != mc || snap_value < 32'd495 || snap_value > 32'd505) begin
                        errors++;
                        $display("FAIL snap got value=%0d cyc=%0d expected value=500+-5 cyc=%0d",
                                 snap_value, cyc, mc);
                    end
                end
            end
`endif
        end
    end

    int s;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_tick_count", tick_count, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cs", tmr.chipselect, 0);
        chk("rst_write_n", tmr.write_n, 1);
        chk("rst_address", tmr.address, 0);
        chk("rst_writedata", tmr.writedata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Periodic, period 10 clocks; a start while busy must be ignored
        start(32'd9, 1'b1, s);
        for (int i = 0; i < 5; i++) push_tk(i + 1, s + 14 + 10 * i);
        wait_until(s + 30);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_until(s + 56);
        push_wr(3'd1, 16'h0008, s + 57);
        push_wr(3'd0, 16'h0000, s + 58);
        pulse_stop();
        wait_until(s + 59);
        chk("periodic_busy_after_stop", busy, 0);
        chk("periodic_tick_count", tick_count, 5);

        // Zero period rejected
        @(negedge clk);
        start(32'd0, 1'b1, s);
        wait_until(s + 2);
        chk("zero_period_busy", busy, 0);

        // Start and stop together in IDLE: nothing happens
        cfg_period = 32'd5; cmd_start = 1'b1; cmd_stop = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_stop = 1'b0;
        @(negedge clk);
        chk("start_stop_same_busy", busy, 0);

        // Stop during WR_PH
        start(32'd9, 1'b1, s);
        push_wr(3'd1, 16'h0008, s + 4);
        push_wr(3'd0, 16'h0000, s + 5);
        wait_until(s + 1);
        pulse_stop();
        wait_until(s + 6);
        chk("prog_stop_busy", busy, 0);
        chk("prog_stop_tick_count", tick_count, 0);
        wait_until(s + 20);
        chk("prog_stop_irq", tmr.irq, 0);

        // Stop in the same cycle irq rises: tick first, then stop
        @(negedge clk);
        start(32'd9, 1'b1, s);
        push_tk(1, s + 14);
        push_wr(3'd1, 16'h0008, s + 15);
        push_wr(3'd0, 16'h0000, s + 16);
        wait_until(s + 13);
        chk("coinc_irq_high", tmr.irq, 1);
        pulse_stop();
        wait_until(s + 17);
        chk("coinc_busy", busy, 0);
        chk("coinc_tick_count", tick_count, 1);

        // Async reset mid-sequence
        @(negedge clk);
        cfg_period = 32'd9; cfg_continuous = 1'b1;
        push_wr(3'd2, 16'd9, cyc + 1);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_cs", tmr.chipselect, 0);
        chk("arst_write_n", tmr.write_n, 1);
        chk("arst_address", tmr.address, 0);
        chk("arst_tick_count", tick_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // One-shot, 65540-clock period
        start(32'h0001_0003, 1'b0, s);
        push_tk(1, s + 65544);
        wait_until(s + 65545);
        chk("oneshot_busy", busy, 0);
        wait_until(s + 65580);
        chk("oneshot_tick_count", tick_count, 1);
        chk("oneshot_irq", tmr.irq, 0);

`ifdef TIMER_SCHED_SNAP_EN
        @(negedge clk);
        start(32'd999, 1'b1, s);
        push_wr(3'd4, 16'h0000, s + 503);
        exp_snap.push_back(s + 507);
        for (int i = 0; i < 3; i++) push_tk(i + 1, s + 1004 + 1000 * i);
        wait_until(s + 502);
        cmd_snap = 1'b1;
        @(negedge clk);
        cmd_snap = 1'b0;
        wait_until(s + 3010);
        push_wr(3'd1, 16'h0008, s + 3011);
        push_wr(3'd0, 16'h0000, s + 3012);
        pulse_stop();
        wait_until(s + 3013);
        chk("snap_busy", busy, 0);
        chk("snap_tick_count", tick_count, 3);
`endif

        repeat (5) @(negedge clk);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_ticks", exp_tk.size(), 0);
        chk("pending_cfg_err", exp_err.size(), 0);
        chk("pending_snap", exp_snap.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
